// File: rtl/cp0_if.sv
// Bus between the pipeline M stage and coprocessor 0: mfc0/mtc0 access,
// exception/interrupt inputs, and the request/EPC/read-data outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BD, ExcCode_in, HWInt, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BD, ExcCode_in, HWInt, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId state, exception and interrupt request
// generation at the M stage, and mfc0/mtc0 register access.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_7A07
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);
  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;
  localparam logic [4:0] RegPrid  = 5'd15;

  logic [5:0]  im, imNext;
  logic        exl, exlNext;
  logic        ie, ieNext;
  logic        causeBd, causeBdNext;
  logic [5:0]  ip, ipNext;
  logic [4:0]  excCode, excCodeNext;
  logic [31:0] epcReg, epcNext;

  logic        intPend, excPend, intReq;
  logic [4:0]  recCode;
  logic [31:0] pcAligned, epcExc, dinAligned;

  // Request decode: interrupts outrank synchronous exceptions, EXL masks both
  always_comb begin
    intPend    = (|(bus.HWInt & im)) & ie & ~exl;
    excPend    = (bus.ExcCode_in != 5'd0) & ~exl;
    intReq     = intPend | excPend;
    recCode    = intPend ? 5'd0 : bus.ExcCode_in;
    pcAligned  = bus.PC & 32'hFFFF_FFFC;
    epcExc     = bus.BD ? (pcAligned - 32'd4) : pcAligned;
    dinAligned = bus.DIn & 32'hFFFF_FFFC;
  end

  // Next-state: a taken request flushes any same-cycle mtc0
  always_comb begin
    imNext      = im;
    exlNext     = exl;
    ieNext      = ie;
    causeBdNext = causeBd;
    excCodeNext = excCode;
    epcNext     = epcReg;
    ipNext      = bus.HWInt;
    if (intReq) begin
      exlNext     = 1'b1;
      excCodeNext = recCode;
      causeBdNext = bus.BD;
      epcNext     = epcExc;
    end else begin
      if (bus.WE && bus.A2 == RegSr) begin
        imNext  = bus.DIn[15:10];
        exlNext = bus.DIn[1];
        ieNext  = bus.DIn[0];
      end
      if (bus.WE && bus.A2 == RegEpc) begin
        epcNext = dinAligned;
      end
      if (bus.EXLClr) begin
        exlNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= 6'd0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      causeBd <= 1'b0;
      ip      <= 6'd0;
      excCode <= 5'd0;
      epcReg  <= 32'd0;
    end else begin
      im      <= imNext;
      exl     <= exlNext;
      ie      <= ieNext;
      causeBd <= causeBdNext;
      ip      <= ipNext;
      excCode <= excCodeNext;
      epcReg  <= epcNext;
    end
  end

  // mfc0 read mux; no bypass of same-cycle writes
  always_comb begin
    bus.DOut = 32'd0;
    case (bus.A1)
      RegSr:    bus.DOut = {16'd0, im, 8'd0, exl, ie};
      RegCause: bus.DOut = {causeBd, 15'd0, ip, 3'd0, excCode, 2'd0};
      RegEpc:   bus.DOut = epcReg;
      RegPrid:  bus.DOut = PRID;
      default:  bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq = intReq;
  assign bus.EPC    = epcReg;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_cp0_unit;
  logic clk;
  logic reset;
  cp0_if bus ();

  cp0_unit #(.PRID(32'h0000_7A07)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int SelIntReq = 0;
  localparam int SelEpc    = 1;
  localparam int SelDOut   = 2;

  string       nameQ[$];
  int          selQ[$];
  logic [31:0] expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", testsRun);
    $fatal(1, "timeout");
  end

  // Monitor: outputs are compared mid-cycle, away from the rising edge
  always @(negedge clk) begin
    while (nameQ.size() > 0) begin
      string       n;
      int          s;
      logic [31:0] e;
      logic [31:0] a;
      n = nameQ.pop_front();
      s = selQ.pop_front();
      e = expQ.pop_front();
      case (s)
        SelIntReq: a = {31'd0, bus.IntReq};
        SelEpc:    a = bus.EPC;
        default:   a = bus.DOut;
      endcase
      testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic expectOut(input string n, input int s, input logic [31:0] v);
    nameQ.push_back(n);
    selQ.push_back(s);
    expQ.push_back(v);
  endtask

  task automatic readReg(input string n, input logic [4:0] r, input logic [31:0] v);
    bus.A1 = r;
    expectOut(n, SelDOut, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.A1 = 5'd0; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF; bus.WE = 1'b1;
    bus.PC = 32'd0; bus.BD = 1'b0; bus.ExcCode_in = 5'd0; bus.HWInt = 6'd0;
    bus.EXLClr = 1'b1;
    step(); step();
    reset = 1'b0; bus.WE = 1'b0; bus.EXLClr = 1'b0; bus.DIn = 32'd0;

    // Reset state
    expectOut("rst_intreq", SelIntReq, 32'd0);
    expectOut("rst_epc", SelEpc, 32'd0);
    readReg("rst_sr", 5'd12, 32'd0);
    step();
    readReg("rst_prid", 5'd15, 32'h0000_7A07);
    step();
    readReg("rst_cause", 5'd13, 32'd0);
    step();

    // Ri exception, not in delay slot
    bus.ExcCode_in = 5'd10; bus.PC = 32'h0000_3010; bus.BD = 1'b0;
    expectOut("ri_intreq", SelIntReq, 32'd1);
    step();
    expectOut("ri_masked", SelIntReq, 32'd0);
    expectOut("ri_epc", SelEpc, 32'h0000_3010);
    readReg("ri_cause", 5'd13, 32'h0000_0028);
    step();
    readReg("ri_sr_exl", 5'd12, 32'h0000_0002);
    step();
    bus.ExcCode_in = 5'd0; bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;

    // Ov in a branch delay slot
    bus.ExcCode_in = 5'd12; bus.PC = 32'h0000_3024; bus.BD = 1'b1;
    expectOut("ov_intreq", SelIntReq, 32'd1);
    step();
    bus.ExcCode_in = 5'd0; bus.BD = 1'b0;
    expectOut("ov_epc", SelEpc, 32'h0000_3020);
    readReg("ov_cause", 5'd13, 32'h8000_0030);
    step();
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;

    // Interrupt outranks a simultaneous AdEL
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    step();
    bus.WE = 1'b0;
    bus.HWInt = 6'b000001; bus.ExcCode_in = 5'd4; bus.PC = 32'h0000_3100;
    expectOut("int_intreq", SelIntReq, 32'd1);
    readReg("int_sr", 5'd12, 32'h0000_0401);
    step();
    bus.ExcCode_in = 5'd0;
    expectOut("int_masked", SelIntReq, 32'd0);
    expectOut("int_epc", SelEpc, 32'h0000_3100);
    readReg("int_cause", 5'd13, 32'h0000_0400);
    step();

    // eret with the interrupt still pending re-fires after the edge
    bus.EXLClr = 1'b1;
    expectOut("eret_same_cycle", SelIntReq, 32'd0);
    step();
    bus.EXLClr = 1'b0;
    expectOut("eret_refire", SelIntReq, 32'd1);
    readReg("eret_sr", 5'd12, 32'h0000_0401);
    step();

    // IM=0 masks the interrupt; IP still tracks HWInt a cycle later
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0001; bus.EXLClr = 1'b1;
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b0; bus.HWInt = 6'b100001;
    expectOut("im0_intreq", SelIntReq, 32'd0);
    readReg("im0_sr", 5'd12, 32'h0000_0001);
    step();
    readReg("im0_cause_ip", 5'd13, 32'h0000_8400);
    step();

    // mtc0 EPC suppressed by a same-cycle AdES
    bus.HWInt = 6'd0;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5000;
    bus.ExcCode_in = 5'd5; bus.PC = 32'h0000_3200;
    expectOut("ades_intreq", SelIntReq, 32'd1);
    step();
    bus.WE = 1'b0; bus.ExcCode_in = 5'd0;
    expectOut("ades_epc", SelEpc, 32'h0000_3200);
    readReg("ades_epc_rd", 5'd14, 32'h0000_3200);
    step();
    readReg("ades_cause", 5'd13, 32'h0000_0014);
    step();
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;

    // Unsuppressed mtc0 EPC, word-aligned
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5003;
    expectOut("mtc0_epc_noreq", SelIntReq, 32'd0);
    step();
    bus.WE = 1'b0;
    expectOut("mtc0_epc", SelEpc, 32'h0000_5000);
    readReg("mtc0_epc_rd", 5'd14, 32'h0000_5000);
    step();

    // Cause is read-only; unmapped registers read 0
    bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    step();
    bus.WE = 1'b0;
    readReg("cause_ro", 5'd13, 32'h0000_0014);
    step();
    readReg("unmapped", 5'd3, 32'd0);
    step();

    // EXLClr beats an mtc0 SR on the EXL bit only
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0003; bus.EXLClr = 1'b1;
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b0;
    readReg("exlclr_wins", 5'd12, 32'h0000_0001);
    step();

    // Reset overrides a same-cycle request and write
    reset = 1'b1; bus.ExcCode_in = 5'd12; bus.PC = 32'h0000_3300;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_7770;
    step();
    reset = 1'b0; bus.ExcCode_in = 5'd0; bus.WE = 1'b0;
    expectOut("rst2_epc", SelEpc, 32'd0);
    expectOut("rst2_intreq", SelIntReq, 32'd0);
    readReg("rst2_sr", 5'd12, 32'd0);
    step();
    readReg("rst2_cause", 5'd13, 32'd0);
    step();

    if (nameQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", nameQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
